// File: rtl/rpn_conv_core.sv
// rpn_conv_core: infix-to-postfix token converter (shunting-yard).
// Numbers pass straight through to the output. Operators are ordered through
// an internal DEPTH-entry operator stack. Errors are sticky, and only reset
// clears them.
// Optional feature macro: RPN_CONV_POW_EN adds "^" (precedence 3,
// right-associative). Without it, "^" is reported as an unknown operator.
//
// Handshakes: a token moves on IN when IN_STB && IN_RDY, and on OUT when
// OUT_STB && OUT_ACK, both at the rising clock edge. OUT_STB stays asserted,
// and OUT_IS_OP/OUT_DAT stay constant, until the token is accepted.
module rpn_conv_core #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_STB,
    output logic          IN_RDY,
    input  logic          IN_IS_OP,
    input  logic [DW-1:0] IN_DAT,
    input  logic          IN_END,
    output logic          OUT_STB,
    input  logic          OUT_ACK,
    output logic          OUT_IS_OP,
    output logic [DW-1:0] OUT_DAT,
    output logic          DONE,
    output logic          ERR,
    output logic [1:0]    ERR_CODE,
    output logic [CW-1:0] LEVEL,
    output logic [3:0]    DBG_STATE
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [7:0] CH_LP  = 8'h28; // "("
    localparam logic [7:0] CH_RP  = 8'h29; // ")"
    localparam logic [7:0] CH_MUL = 8'h2A; // "*"
    localparam logic [7:0] CH_ADD = 8'h2B; // "+"
    localparam logic [7:0] CH_SUB = 8'h2D; // "-"
    localparam logic [7:0] CH_DIV = 8'h2F; // "/"
    localparam logic [7:0] CH_POW = 8'h5E; // "^"

    localparam logic [1:0] E_OVF   = 2'd1;
    localparam logic [1:0] E_PAREN = 2'd2;
    localparam logic [1:0] E_UNK   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_EMIT_NUM = 4'd1,
        S_EVAL     = 4'd2,
        S_POP_EMIT = 4'd3,
        S_PUSH     = 4'd4,
        S_PAREN    = 4'd5,
        S_FLUSH    = 4'd6,
        S_DONE     = 4'd7,
        S_ERROR    = 4'd8
    } state_e;

    // Precedence of a binary operator. A non-operator returns 0.
    function automatic logic [1:0] prec_of(input logic [7:0] c);
        case (c)
            CH_ADD, CH_SUB: prec_of = 2'd1;
            CH_MUL, CH_DIV: prec_of = 2'd2;
`ifdef RPN_CONV_POW_EN
            CH_POW:         prec_of = 2'd3;
`endif
            default:        prec_of = 2'd0;
        endcase
    endfunction

    // True for every operator code the core understands, parentheses included.
    function automatic logic known_op(input logic [7:0] c);
        known_op = (c == CH_LP) || (c == CH_RP) || (prec_of(c) != 2'd0);
    endfunction

    function automatic logic right_assoc(input logic [7:0] c);
`ifdef RPN_CONV_POW_EN
        right_assoc = (c == CH_POW);
`else
        right_assoc = 1'b0 && (c == CH_POW);
`endif
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   lvl_q, lvl_d;
    logic [7:0]      op_q, op_d;
    logic [DW-1:0]   num_q, num_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic            rst_meta_q, rst_sync_q;
    logic [7:0]      stack_q [DEPTH];
    logic            push_en;
    logic [AW-1:0]   top_idx;
    logic [7:0]      top;
    logic            empty, full, pop_cond;

    // The reset asserts asynchronously and releases synchronously to CLK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign top_idx  = lvl_q[AW-1:0] - AW'(1);
    assign top      = stack_q[top_idx];
    assign empty    = (lvl_q == '0);
    assign full     = (lvl_q == CW'(DEPTH));
    // Pop while the stacked operator binds at least as tightly as the one
    // held in op_q. For a right-associative operator it must bind strictly
    // tighter.
    assign pop_cond = !empty && (top != CH_LP) &&
                      (right_assoc(op_q) ? (prec_of(top) >  prec_of(op_q))
                                         : (prec_of(top) >= prec_of(op_q)));

    // Operator stack storage. Occupancy lives in lvl_q, so the entries
    // themselves need no reset.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_q[lvl_q[AW-1:0]] <= op_q;
        end
    end

    // State, occupancy, held token and sticky error registers.
    always_ff @(posedge CLK or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= S_IDLE;
            lvl_q   <= '0;
            op_q    <= '0;
            num_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            op_q    <= op_d;
            num_q   <= num_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Next-state logic and output decode for the conversion FSM.
    always_comb begin
        state_d   = state_q;
        lvl_d     = lvl_q;
        op_d      = op_q;
        num_d     = num_q;
        err_d     = err_q;
        code_d    = code_q;
        push_en   = 1'b0;
        IN_RDY    = 1'b0;
        OUT_STB   = 1'b0;
        OUT_IS_OP = 1'b0;
        OUT_DAT   = '0;
        DONE      = 1'b0;

        case (state_q)
            S_IDLE: begin
                IN_RDY = rst_sync_q;
                if (IN_STB && rst_sync_q) begin
                    if (IN_END) begin
                        state_d = S_FLUSH;
                    end else if (!IN_IS_OP) begin
                        num_d   = IN_DAT;
                        state_d = S_EMIT_NUM;
                    end else begin
                        op_d    = IN_DAT[7:0];
                        state_d = S_EVAL;
                    end
                end
            end
            S_EMIT_NUM: begin
                OUT_STB = 1'b1;
                OUT_DAT = num_q;
                if (OUT_ACK) begin
                    state_d = S_IDLE;
                end
            end
            S_EVAL: begin
                if (!known_op(op_q)) begin
                    state_d = S_ERROR;
                    if (!err_q) begin
                        err_d  = 1'b1;
                        code_d = E_UNK;
                    end
                end else if (op_q == CH_LP) begin
                    if (full) begin
                        state_d = S_ERROR;
                        if (!err_q) begin
                            err_d  = 1'b1;
                            code_d = E_OVF;
                        end
                    end else begin
                        push_en = 1'b1;
                        lvl_d   = lvl_q + CW'(1);
                        state_d = S_IDLE;
                    end
                end else if (op_q == CH_RP) begin
                    state_d = S_PAREN;
                end else if (pop_cond) begin
                    state_d = S_POP_EMIT;
                end else begin
                    state_d = S_PUSH;
                end
            end
            S_POP_EMIT: begin
                OUT_STB      = 1'b1;
                OUT_IS_OP    = 1'b1;
                OUT_DAT[7:0] = top;
                if (OUT_ACK) begin
                    lvl_d   = lvl_q - CW'(1);
                    state_d = S_EVAL;
                end
            end
            S_PUSH: begin
                if (full) begin
                    state_d = S_ERROR;
                    if (!err_q) begin
                        err_d  = 1'b1;
                        code_d = E_OVF;
                    end
                end else begin
                    push_en = 1'b1;
                    lvl_d   = lvl_q + CW'(1);
                    state_d = S_IDLE;
                end
            end
            S_PAREN: begin
                if (empty) begin
                    state_d = S_ERROR;
                    if (!err_q) begin
                        err_d  = 1'b1;
                        code_d = E_PAREN;
                    end
                end else if (top == CH_LP) begin
                    lvl_d   = lvl_q - CW'(1);
                    state_d = S_IDLE;
                end else begin
                    OUT_STB      = 1'b1;
                    OUT_IS_OP    = 1'b1;
                    OUT_DAT[7:0] = top;
                    if (OUT_ACK) begin
                        lvl_d = lvl_q - CW'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (empty) begin
                    state_d = S_DONE;
                end else if (top == CH_LP) begin
                    state_d = S_ERROR;
                    if (!err_q) begin
                        err_d  = 1'b1;
                        code_d = E_PAREN;
                    end
                end else begin
                    OUT_STB      = 1'b1;
                    OUT_IS_OP    = 1'b1;
                    OUT_DAT[7:0] = top;
                    if (OUT_ACK) begin
                        lvl_d = lvl_q - CW'(1);
                    end
                end
            end
            S_DONE: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase
    end

    assign ERR       = err_q;
    assign ERR_CODE  = code_q;
    assign LEVEL     = lvl_q;
    assign DBG_STATE = state_q;

endmodule

// File: doc/rpn_conv_core.md
Name: rpn_conv_core

Overview:
- Parametrised successor of the sign/number infix-to-postfix converter.
- Accepts one infix token stream (numbers and ASCII operators, including parentheses) and emits postfix tokens using the shunting-yard algorithm.
- Owns its operator stack (DEPTH entries), supports back-pressure on the output, and reports errors.
- Sits between the token reader and the postfix evaluator.

Parameters:
- DW, 8, width of number payload and of the ASCII operator field.
- DEPTH, 16, operator stack entries (power of 2, >=2).
- CW, $clog2(DEPTH+1), stack counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_STB  in  1  input token valid.
- IN_RDY  out  1  core can accept a token; a transfer occurs when IN_STB&&IN_RDY.
- IN_IS_OP  in  1  1 = operator/paren token, 0 = number.
- IN_DAT  in  DW  number value, or ASCII code in [7:0] for operators.
- IN_END  in  1  end-of-expression marker; IN_DAT and IN_IS_OP are ignored.
- OUT_STB  out  1  output token valid; held until accepted.
- OUT_ACK  in  1  sink accepts; a transfer occurs when OUT_STB&&OUT_ACK.
- OUT_IS_OP  out  1  output token is an operator.
- OUT_DAT  out  DW  number or ASCII operator, zero-extended.
- DONE  out  1  one-cycle pulse after the final flush completes.
- ERR  out  1  sticky error flag, cleared only by reset.
- ERR_CODE  out  2  error cause: 1 = stack overflow, 2 = paren mismatch, 3 = unknown operator.
- LEVEL  out  CW  current stack occupancy.

Behaviour:
- Reset (async assert, sync deassert inside block): all outputs 0, IN_RDY=0 during reset, state IDLE, stack empty.
- IN_RDY=1 only in IDLE with no pending output. Tokens are consumed one per transfer.
- Operator codes: + - = prec 1; * / = prec 2; "(" = prec 0 marker; ")" closes a group.
- States:
  - IDLE: on a number, latch it to the output and go to EMIT_NUM. On an operator, go to EVAL. On IN_END, go to FLUSH.
  - EMIT_NUM: OUT_STB=1, OUT_IS_OP=0; on ACK go to IDLE.
  - EVAL ("("): push, go to IDLE.
  - EVAL (")"): go to PAREN.
  - EVAL (other): if stack non-empty, top!="(" and prec(top)>=prec(in), go to POP_EMIT. Otherwise go to PUSH.
  - POP_EMIT: present top, OUT_IS_OP=1; on ACK pop and return to EVAL. Re-evaluate with the same held operator.
  - PUSH: write the incoming operator, LEVEL+1, go to IDLE.
  - PAREN: top=="(" → pop and discard, go to IDLE. Top is an operator → emit, pop on ACK, stay in PAREN. Stack empty → ERR code 2.
  - FLUSH: emit and pop until empty, then go to DONE. A "(" found during flush → ERR code 2.
  - DONE: DONE=1 for one cycle, go to IDLE.
  - ERROR: IN_RDY=0, OUT_STB=0; only reset exits this state.
- Push into a full stack (LEVEL==DEPTH): push suppressed, ERR code 1.
- Unknown ASCII operator: ERR code 3.
- The first error wins; ERR_CODE is not overwritten by later errors.
- OUT_DAT and OUT_IS_OP are stable while OUT_STB=1 and ACK=0.
- A one-cycle gap between output tokens is allowed. Throughput target is one token per two cycles.
- IN_END in the same beat as a token is impossible by protocol: IN_END overrides the token.
- Reset mid-expression discards the stack and any pending output immediately.
- Empty expression (IN_END first): DONE pulses, no output.

Optional Feature:
- Macro RPN_CONV_POW_EN.
- When defined: "^" is prec 3 and right-associative. Pop condition in EVAL becomes prec(top)>prec(in) for "^".
- When undefined: "^" is an unknown operator and sets ERR code 3.

Test Plan:
- 3+4*2 END, OUT_ACK=1 → 3,4,2,*,+ then DONE pulse; LEVEL returns to 0.
- (1+2)*3 END with OUT_ACK toggling every other cycle → 1,2,+,3,* emitted. Each output is stable under stall.
- 8-2-1 END → 8,2,-,1,- (left associativity).
- DEPTH=4, feed "(((((": 5th "(" → ERR=1, ERR_CODE=1, IN_RDY=0. Reset mid-expression restores IN_RDY=1, LEVEL=0.
- "1+2)" → ERR_CODE=2 with output 1,2,+. "(1" END → ERR_CODE=2. "1%2" → ERR_CODE=3.
- RPN_CONV_POW_EN defined, 2^3^2 END → 2,3,2,^,^. Undefined: "^" gives ERR_CODE=3.
